// File: rtl/alu_result_bcd_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_bcd_if
// Description : Request/result bundle for the ALU-result BCD converter.
//               master - requester (drives start/value/is_signed)
//               slave  - converter (drives busy/done/bcd/negative)
// Ports       : start, value[WIDTH-1:0], is_signed  (requester -> converter)
//               busy, done, bcd[4*DIGITS-1:0], negative (converter -> requester)
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_result_bcd_if #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 7
);
  logic                  start;
  logic [WIDTH-1:0]      value;
  logic                  is_signed;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  negative;

  modport master (
    output start, value, is_signed,
    input  busy, done, bcd, negative
  );

  modport slave (
    input  start, value, is_signed,
    output busy, done, bcd, negative
  );
endinterface
`default_nettype wire

// File: rtl/alu_result_bcd.sv
`default_nettype none
// ============================================================================
// Module      : alu_result_bcd
// Description : Sequential binary-to-BCD converter (double-dabble, one bit
//               per clock) for the mini-ALU result bus. Optionally treats the
//               input as two's complement and emits magnitude plus sign.
// Ports       : clk  - rising-edge clock
//               rst  - asynchronous active-high reset
//               bus  - alu_result_bcd_if.slave (start/value/is_signed in,
//                      busy/done/bcd/negative out)
// Revision    : 1.0 - initial release
// ============================================================================
module alu_result_bcd #(
  parameter int WIDTH  = 20,
  parameter int DIGITS = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_result_bcd_if.slave      bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int ACC_W = 4 * DIGITS;

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [WIDTH-1:0]  shift_q, shift_d;
  logic [ACC_W-1:0]  acc_q,   acc_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              sign_q,  sign_d;
  logic [ACC_W-1:0]  bcd_q,   bcd_d;
  logic              neg_q,   neg_d;
  logic              done_q,  done_d;

  logic [WIDTH-1:0]        magnitude;
  logic [ACC_W-1:0]        acc_adj;
  logic [ACC_W+WIDTH-1:0]  shifted;

  // Two's-complement negate; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude.
  assign magnitude = (bus.is_signed && bus.value[WIDTH-1])
                   ? (~bus.value + WIDTH'(1))
                   : bus.value;

  // Add-3 correction on every digit >= 5 so the following shift carries
  // correctly into the next decimal digit.
  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_dabble
      assign acc_adj[4*i +: 4] = (acc_q[4*i +: 4] >= 4'd5)
                               ? (acc_q[4*i +: 4] + 4'd3)
                               : acc_q[4*i +: 4];
    end
  endgenerate

  // One double-dabble step: shift {accumulator, magnitude} left by one.
  assign shifted = {acc_adj, shift_q} << 1;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    bcd_d   = bcd_q;
    neg_d   = neg_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          shift_d = magnitude;
          sign_d  = bus.is_signed & bus.value[WIDTH-1];
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_CONVERT;
        end
      end
      S_CONVERT: begin
        acc_d   = shifted[ACC_W+WIDTH-1:WIDTH];
        shift_d = shifted[WIDTH-1:0];
        cnt_d   = cnt_q - CNT_W'(1);
        // Last shift: publish result directly from the shifted value so
        // bcd is valid on the same edge that ends the conversion.
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted[ACC_W+WIDTH-1:WIDTH];
          neg_d   = sign_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      bcd_q   <= '0;
      neg_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      bcd_q   <= bcd_d;
      neg_q   <= neg_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = (state_q == S_CONVERT);
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.negative = neg_q;

endmodule
`default_nettype wire
